// File: rtl/tone_decoder.sv
// Measures period and high time of an incoming square-wave tone, classifies the
// period against the 16-note game table and reports a debounced note and level.
module tone_decoder #(
  parameter int unsigned CLK_HZ      = 50_000_000,
  parameter int unsigned TOL_SHIFT   = 7,
  parameter int unsigned STABLE      = 3,
  parameter int unsigned TIMEOUT_CYC = 262144
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tone_in,
  output logic [4:0]  note,
  output logic [2:0]  level,
  output logic        note_valid,
  output logic        note_change,
  output logic [17:0] period
);

  localparam int unsigned CNT_W      = $clog2(TIMEOUT_CYC + 2);
  localparam int unsigned RUN_W      = $clog2(STABLE + 1);
  localparam int unsigned PERIOD_MAX = (1 << 18) - 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC);
  localparam int unsigned NOTE_HZ [16] = '{262, 294, 330, 349, 392, 415, 440, 494,
                                           523, 587, 659, 698, 784, 831, 880, 988};

  typedef enum logic [1:0] {SILENT, ARMED, LOCKED} state_e;

  function automatic logic in_window(input int unsigned f, input logic [CNT_W-1:0] cap);
    int unsigned nom;
    int unsigned tol;
    nom = CLK_HZ / f;
    tol = nom >> TOL_SHIFT;
    return (32'(cap) >= nom - tol) && (32'(cap) <= nom + tol);
  endfunction

  // Level k covers [k*f - f/2, k*f + f/2); count how many upper bounds high clears.
  function automatic logic [2:0] level_of(input int unsigned f, input logic [CNT_W-1:0] high);
    logic [2:0] lvl;
    lvl = 3'd1;
    for (int unsigned k = 1; k <= 6; k++) begin
      if (32'(high) >= k * f + f / 2) lvl = 3'(k + 1);
    end
    return lvl;
  endfunction

  // Input conditioning and counters
  logic             sync1_q, sync1_d, sync2_q, sync2_d, edge_q, edge_d;
  logic [CNT_W-1:0] per_cnt_q, per_cnt_d, high_cnt_q, high_cnt_d, high_q, high_d;
  logic             rise, fall, timeout;
  logic [CNT_W-1:0] cap;

  // Classification stage
  logic             cls_valid_q, cls_valid_d;
  logic [4:0]       cls_code_q, cls_code_d;
  logic [2:0]       cls_level_q, cls_level_d;
  logic [17:0]      cls_period_q, cls_period_d;

  // Stability FSM and output registers
  state_e           state_q, state_d;
  logic [4:0]       cand_q, cand_d;
  logic [RUN_W-1:0] run_q, run_d, run_next;
  logic             same_cand, reach;
  logic [4:0]       note_q, note_d;
  logic [2:0]       level_q, level_d;
  logic             valid_q, valid_d;
  logic             change_q, change_d;
  logic [17:0]      period_q, period_d;

  assign rise = sync2_q & ~edge_q;
  assign fall = ~sync2_q & edge_q;
  assign cap  = per_cnt_q + CNT_W'(1);
  // NOTE: a rise landing on the saturated count is a real edge, so it masks the timeout.
  assign timeout = (per_cnt_q == CNT_MAX) && !rise;

  always_comb begin
    // NOTE: tone_in is asynchronous; only sync2_q and later are safe to use as logic.
    sync1_d    = tone_in;
    sync2_d    = sync1_q;
    edge_d     = sync2_q;
    per_cnt_d  = per_cnt_q;
    high_cnt_d = high_cnt_q;
    high_d     = high_q;
    if (rise) per_cnt_d = '0;
    else if (per_cnt_q != CNT_MAX) per_cnt_d = per_cnt_q + CNT_W'(1);
    if (rise) high_cnt_d = '0;
    else if (edge_q && high_cnt_q != CNT_MAX) high_cnt_d = high_cnt_q + CNT_W'(1);
    if (fall) high_d = high_cnt_q + CNT_W'(1);
  end

  always_comb begin
    cls_code_d  = '0;
    cls_level_d = '0;
    for (int c = 0; c < 16; c++) begin
      if (in_window(NOTE_HZ[c], cap)) begin
        cls_code_d  = 5'(c + 1);
        cls_level_d = level_of(NOTE_HZ[c], high_q);
      end
    end
    cls_valid_d  = rise;
    cls_period_d = (32'(cap) > PERIOD_MAX) ? 18'(PERIOD_MAX) : 18'(cap);
  end

  always_comb begin
    state_d   = state_q;
    cand_d    = cand_q;
    run_d     = run_q;
    note_d    = note_q;
    level_d   = level_q;
    valid_d   = valid_q;
    period_d  = period_q;
    same_cand = (cls_code_q == cand_q) && (run_q != '0);
    run_next  = same_cand ? run_q + RUN_W'(1) : RUN_W'(1);
    reach     = (32'(run_next) >= STABLE);
    if (timeout) begin
      state_d = SILENT;
      cand_d  = '0;
      run_d   = '0;
      note_d  = '0;
      level_d = '0;
      valid_d = 1'b0;
    end else if (cls_valid_q) begin
      unique case (state_q)
        SILENT: begin
          state_d = ARMED;
          cand_d  = '0;
          run_d   = '0;
        end
        ARMED: begin
          period_d = cls_period_q;
          if (cls_code_q == '0) begin
            cand_d = '0;
            run_d  = '0;
          end else if (reach) begin
            state_d = LOCKED;
            note_d  = cls_code_q;
            level_d = cls_level_q;
            valid_d = 1'b1;
            cand_d  = '0;
            run_d   = '0;
          end else begin
            cand_d = cls_code_q;
            run_d  = run_next;
          end
        end
        LOCKED: begin
          period_d = cls_period_q;
          if (cls_code_q == note_q) begin
            level_d = cls_level_q;
            cand_d  = '0;
            run_d   = '0;
          end else if (reach) begin
            cand_d = '0;
            run_d  = '0;
            if (cls_code_q == '0) begin
              state_d = ARMED;
              note_d  = '0;
              level_d = '0;
              valid_d = 1'b0;
            end else begin
              note_d  = cls_code_q;
              level_d = cls_level_q;
            end
          end else begin
            // Candidate code 0 tracks a run of UNKNOWN periods while locked.
            cand_d = cls_code_q;
            run_d  = run_next;
          end
        end
        default: state_d = SILENT;
      endcase
    end
    change_d = {valid_d, note_d, level_d} != {valid_q, note_q, level_q};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      edge_q       <= 1'b0;
      per_cnt_q    <= '0;
      high_cnt_q   <= '0;
      high_q       <= '0;
      cls_valid_q  <= 1'b0;
      cls_code_q   <= '0;
      cls_level_q  <= '0;
      cls_period_q <= '0;
      state_q      <= SILENT;
      cand_q       <= '0;
      run_q        <= '0;
      note_q       <= '0;
      level_q      <= '0;
      valid_q      <= 1'b0;
      change_q     <= 1'b0;
      period_q     <= '0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      edge_q       <= edge_d;
      per_cnt_q    <= per_cnt_d;
      high_cnt_q   <= high_cnt_d;
      high_q       <= high_d;
      cls_valid_q  <= cls_valid_d;
      cls_code_q   <= cls_code_d;
      cls_level_q  <= cls_level_d;
      cls_period_q <= cls_period_d;
      state_q      <= state_d;
      cand_q       <= cand_d;
      run_q        <= run_d;
      note_q       <= note_d;
      level_q      <= level_d;
      valid_q      <= valid_d;
      change_q     <= change_d;
      period_q     <= period_d;
    end
  end

  assign note        = note_q;
  assign level       = level_q;
  assign note_valid  = valid_q;
  assign note_change = change_q;
  assign period      = period_q;

endmodule
